// File: rtl/sha256_padder_if.sv
// Handshake bundle between the message source, the padder, the message-block
// RAM and the compression core.
//   in_*      : big-endian 32-bit word stream (valid/ready), last flag, byte count
//   ram_*     : registered write port into the 16-word block RAM
//   blk_*     : block-ready handshake toward the compression core
// slave is the padder side; master is the source/core/RAM side.
interface sha256_padder_if #(
    parameter int unsigned RAM_AW = 4
);
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_last;
    logic [2:0]        in_nbytes;
    logic              in_ready;
    logic [RAM_AW-1:0] ram_waddr;
    logic [31:0]       ram_wdata;
    logic              ram_wen;
    logic              blk_valid;
    logic              blk_last;
    logic              blk_ack;

    modport master (
        output in_data, in_valid, in_last, in_nbytes, blk_ack,
        input  in_ready, ram_waddr, ram_wdata, ram_wen, blk_valid, blk_last
    );

    modport slave (
        input  in_data, in_valid, in_last, in_nbytes, blk_ack,
        output in_ready, ram_waddr, ram_wdata, ram_wen, blk_valid, blk_last
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: accepts a 32-bit word stream, appends the 0x80
// marker, zero fill and the 64-bit message bit length, writing each 512-bit
// block as 16 words (addresses 0..15) into the block RAM, then holds
// blk_valid until blk_ack.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sha256_padder_if.slave (stream in, RAM write, block handshake)
module sha256_padder #(
    parameter int unsigned RAM_AW    = 4,
    parameter int unsigned LEN_WIDTH = 64
) (
    input logic            clk,
    input logic            rst_n,
    sha256_padder_if.slave bus
);
    typedef enum logic [2:0] {
        S_LOAD,
        S_MARK,
        S_ZERO,
        S_LEN_HI,
        S_LEN_LO,
        S_WAIT
    } state_t;

    state_t               state, state_nx;
    logic [3:0]           w, w_nx;
    logic [LEN_WIDTH-1:0] bitlen, bitlen_nx;
    logic                 msg_done, msg_done_nx;
    logic                 mark_pend, mark_pend_nx;
    logic                 wen, wen_nx;
    logic [RAM_AW-1:0]    waddr, waddr_nx;
    logic [31:0]          wdata, wdata_nx;
    logic                 valid, valid_nx;
    logic                 last, last_nx;

    logic [2:0]           nb;
    logic [31:0]          marked;
    logic [63:0]          len64;

    // State after the word holding the marker was written at index idx.
    function automatic state_t after_mark(input logic [3:0] idx);
        if (idx == 4'd15)      return S_WAIT;    // marker filled the block
        else if (idx == 4'd13) return S_LEN_HI;  // length fits right away
        else                   return S_ZERO;    // ZERO stops at 13 or 15
    endfunction

    assign nb    = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
    assign len64 = 64'(bitlen);

    // Final partial word: keep bytes below nb, marker in byte nb.
    always_comb begin
        case (nb)
            3'd0:    marked = 32'h8000_0000;
            3'd1:    marked = {bus.in_data[31:24], 24'h80_0000};
            3'd2:    marked = {bus.in_data[31:16], 16'h8000};
            default: marked = {bus.in_data[31:8], 8'h80};
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nx     = state;
        w_nx         = w;
        bitlen_nx    = bitlen;
        msg_done_nx  = msg_done;
        mark_pend_nx = mark_pend;
        wen_nx       = 1'b0;
        waddr_nx     = '0;
        wdata_nx     = '0;
        valid_nx     = valid;
        last_nx      = last;

        case (state)
            S_LOAD: begin
                if (bus.in_valid) begin
                    wen_nx   = 1'b1;
                    waddr_nx = RAM_AW'(w);
                    w_nx     = w + 4'd1;
                    if (!bus.in_last) begin
                        wdata_nx  = bus.in_data;
                        bitlen_nx = bitlen + LEN_WIDTH'(32);
                        if (w == 4'd15) begin
                            state_nx = S_WAIT;
                            last_nx  = 1'b0;
                        end
                    end else begin
                        msg_done_nx = 1'b1;
                        bitlen_nx   = bitlen + LEN_WIDTH'({nb, 3'b000});
                        if (nb == 3'd4) begin
                            wdata_nx = bus.in_data;
                            // A full final word at index 15 defers its marker
                            // to the start of the next block.
                            if (w == 4'd15) begin
                                state_nx     = S_WAIT;
                                mark_pend_nx = 1'b1;
                                last_nx      = 1'b0;
                            end else begin
                                state_nx = S_MARK;
                            end
                        end else begin
                            wdata_nx = marked;
                            state_nx = after_mark(w);
                        end
                    end
                end
            end
            S_MARK: begin
                wen_nx       = 1'b1;
                waddr_nx     = RAM_AW'(w);
                wdata_nx     = 32'h8000_0000;
                w_nx         = w + 4'd1;
                mark_pend_nx = 1'b0;
                state_nx     = after_mark(w);
            end
            S_ZERO: begin
                wen_nx   = 1'b1;
                waddr_nx = RAM_AW'(w);
                w_nx     = w + 4'd1;
                if (w == 4'd13)      state_nx = S_LEN_HI;
                else if (w == 4'd15) state_nx = S_WAIT;
            end
            S_LEN_HI: begin
                wen_nx   = 1'b1;
                waddr_nx = RAM_AW'(w);
                wdata_nx = len64[63:32];
                w_nx     = w + 4'd1;
                state_nx = S_LEN_LO;
            end
            S_LEN_LO: begin
                wen_nx   = 1'b1;
                waddr_nx = RAM_AW'(w);
                wdata_nx = len64[31:0];
                w_nx     = w + 4'd1;
                state_nx = S_WAIT;
                last_nx  = 1'b1;
            end
            S_WAIT: begin
                // valid rises one edge after entry, so the address-15 write
                // has completed before the core sees the block.
                if (valid && bus.blk_ack) begin
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                    w_nx     = 4'd0;
                    if (last) begin
                        bitlen_nx   = '0;
                        msg_done_nx = 1'b0;
                        state_nx    = S_LOAD;
                    end else if (msg_done) begin
                        state_nx = mark_pend ? S_MARK : S_ZERO;
                    end else begin
                        state_nx = S_LOAD;
                    end
                end else begin
                    valid_nx = 1'b1;
                end
            end
            default: state_nx = S_LOAD;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            w         <= 4'd0;
            bitlen    <= '0;
            msg_done  <= 1'b0;
            mark_pend <= 1'b0;
            wen       <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
        end else begin
            state     <= state_nx;
            w         <= w_nx;
            bitlen    <= bitlen_nx;
            msg_done  <= msg_done_nx;
            mark_pend <= mark_pend_nx;
            wen       <= wen_nx;
            waddr     <= waddr_nx;
            wdata     <= wdata_nx;
            valid     <= valid_nx;
            last      <= last_nx;
        end
    end

    assign bus.in_ready  = rst_n && (state == S_LOAD);
    assign bus.ram_wen   = wen;
    assign bus.ram_waddr = waddr;
    assign bus.ram_wdata = wdata;
    assign bus.blk_valid = valid;
    assign bus.blk_last  = last;
endmodule
